// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the two-port memory bus arbiter
package mem_bus_arbiter_pkg;

  localparam logic [15:0] LED_ADDR_DEF = 16'h000F;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } port_e;

  // One outstanding read return: which port gets it and whether it comes from the LED register
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_led;
  } rd_pend_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester-side bus bundle for the two-port arbiter
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_grant2.sv
// rtl/mem_bus_arbiter_rr_grant2.sv - two-way round-robin grant with bounded burst hold
module rr_grant2
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic [1:0]    req,
  input  port_e         owner,
  input  logic [CW-1:0] burst_cnt,
  input  port_e         last,
  output logic [1:0]    gnt
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  logic win;

  always_comb begin
    gnt = 2'b00;
    win = 1'b0;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Contention: fresh arbitration alternates, a running burst keeps the bus until it hits the cap
        if (burst_cnt == '0)
          win = ~last;
        else if (burst_cnt < MAX_CNT)
          win = owner;
        else
          win = ~owner;
        gnt = win ? 2'b10 : 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one synchronous memory port between core and DMA, owns the LED register
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int             AW        = 16,
  parameter int             DW        = 32,
  parameter logic [AW-1:0]  LED_ADDR  = AW'(LED_ADDR_DEF),
  parameter int             LED_W     = 10,
  parameter int             MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  input  logic [DW-1:0]       mem_rdata,
  output logic [LED_W-1:0]    ledr
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  port_e          owner;
  port_e          last;
  logic [CW-1:0]  burst_cnt;
  rd_pend_t       rd_pend;
  logic [AW-1:0]  addr_hold;

  logic [1:0]     req;
  logic [1:0]     gnt_raw;
  logic [1:0]     gnt;
  logic           accept;
  port_e          sel_port;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           sel_is_led;

  assign req = {bus.req1, bus.req0};

  rr_grant2 #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_grant (
    .req       (req),
    .owner     (owner),
    .burst_cnt (burst_cnt),
    .last      (last),
    .gnt       (gnt_raw)
  );

  assign gnt      = reset ? 2'b00 : gnt_raw;
  assign bus.gnt0 = gnt[0];
  assign bus.gnt1 = gnt[1];
  // The grant only ever goes to a requesting port, so any grant is an accepted beat
  assign accept   = |gnt;

  assign sel_port   = gnt[1] ? PORT_DMA : PORT_CORE;
  assign sel_we     = gnt[1] ? bus.we1    : bus.we0;
  assign sel_addr   = gnt[1] ? bus.addr1  : bus.addr0;
  assign sel_wdata  = gnt[1] ? bus.wdata1 : bus.wdata0;
  assign sel_is_led = (sel_addr == LED_ADDR);

  assign mem_addr  = accept ? sel_addr : addr_hold;
  assign mem_wdata = sel_wdata;
  assign mem_we    = accept && sel_we && !sel_is_led;

  assign bus.rvalid0 = !reset && rd_pend.valid && (rd_pend.port == PORT_CORE);
  assign bus.rvalid1 = !reset && rd_pend.valid && (rd_pend.port == PORT_DMA);
  assign bus.rdata   = rd_pend.is_led ? {{(DW-LED_W){1'b0}}, ledr} : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= PORT_CORE;
      last      <= PORT_DMA;
      burst_cnt <= '0;
      rd_pend   <= '0;
      ledr      <= '0;
      addr_hold <= '0;
    end else begin
      addr_hold <= mem_addr;
      rd_pend   <= '{valid: accept && !sel_we, port: sel_port, is_led: sel_is_led};
      if (accept) begin
        last  <= sel_port;
        owner <= sel_port;
        if (owner == sel_port)
          burst_cnt <= (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
        if (sel_we && sel_is_led)
          ledr <= sel_wdata[LED_W-1:0];
      end else begin
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench: directed vector table, corner sequences, randomized model run
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LED_W = 10;
  localparam int MAX_BURST = 4;
  localparam logic [15:0] LED_A = 16'h000F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             mem_we;
  logic [LED_W-1:0] ledr;

  mem_bus_arbiter #(
    .AW(AW), .DW(DW), .LED_ADDR(LED_A), .LED_W(LED_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .ledr      (ledr)
  );

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  rw0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic [1:0]  rw1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [4:0]  exp;
    logic [31:0] rd;
    logic [9:0]  led;
  } vec_t;

  vec_t tbl [11];

  // Reference model state for the random run
  int          m_owner, m_last, m_streak, m_win;
  logic [9:0]  m_led;
  logic [31:0] m_mem [int];
  logic        m_pv;
  int          m_pp;
  logic [31:0] m_pd;
  logic        act [2];
  logic        wr [2];
  logic [15:0] ad [2];
  logic [31:0] dt [2];
  logic [31:0] val;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    // {req,we} per port, exp = {gnt0,gnt1,mem_we,rvalid0,rvalid1}
    tbl[0]  = '{2'b10, 16'h0010, 32'h0,        2'b00, 16'h0,    32'h0,        5'b10000, 32'h0,        10'h000};
    tbl[1]  = '{2'b11, 16'h000F, 32'h155,      2'b00, 16'h0,    32'h0,        5'b10010, 32'h0,        10'h000};
    tbl[2]  = '{2'b10, 16'h000F, 32'h0,        2'b00, 16'h0,    32'h0,        5'b10000, 32'h0,        10'h155};
    tbl[3]  = '{2'b00, 16'h0,    32'h0,        2'b11, 16'h0040, 32'hDEADBEEF, 5'b01110, 32'h155,      10'h155};
    tbl[4]  = '{2'b00, 16'h0,    32'h0,        2'b10, 16'h0040, 32'h0,        5'b01000, 32'h0,        10'h155};
    tbl[5]  = '{2'b00, 16'h0,    32'h0,        2'b00, 16'h0,    32'h0,        5'b00001, 32'hDEADBEEF, 10'h155};
    tbl[6]  = '{2'b10, 16'h0040, 32'h0,        2'b10, 16'h000F, 32'h0,        5'b10000, 32'h0,        10'h155};
    tbl[7]  = '{2'b00, 16'h0,    32'h0,        2'b10, 16'h000F, 32'h0,        5'b01010, 32'hDEADBEEF, 10'h155};
    tbl[8]  = '{2'b00, 16'h0,    32'h0,        2'b00, 16'h0,    32'h0,        5'b00001, 32'h155,      10'h155};
    tbl[9]  = '{2'b11, 16'h000F, 32'hFFFFF2AA, 2'b00, 16'h0,    32'h0,        5'b10000, 32'h0,        10'h155};
    tbl[10] = '{2'b00, 16'h0,    32'h0,        2'b00, 16'h0,    32'h0,        5'b00000, 32'h0,        10'h2AA};

    // Reset held two cycles while port 0 requests
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt0", 32'(bus.gnt0), 32'h0);
      chk("rst_rvalid0", 32'(bus.rvalid0), 32'h0);
      chk("rst_rvalid1", 32'(bus.rvalid1), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_ledr", 32'(ledr), 32'h0);
      next_cycle();
    end
    reset = 1'b0;

    // Directed vector table, first row is the first cycle out of reset
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rw0[1], tbl[i].rw0[0], tbl[i].a0, tbl[i].d0,
            tbl[i].rw1[1], tbl[i].rw1[0], tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].exp[4]));
      chk($sformatf("v%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].exp[3]));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].exp[2]));
      chk($sformatf("v%0d_rvalid0", i), 32'(bus.rvalid0), 32'(tbl[i].exp[1]));
      chk($sformatf("v%0d_rvalid1", i), 32'(bus.rvalid1), 32'(tbl[i].exp[0]));
      chk($sformatf("v%0d_ledr", i), 32'(ledr), 32'(tbl[i].led));
      if (tbl[i].exp[1] || tbl[i].exp[0])
        chk($sformatf("v%0d_rdata", i), bus.rdata, tbl[i].rd);
      if (tbl[i].exp[2])
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].exp[3] ? tbl[i].a1 : tbl[i].a0));
      next_cycle();
    end

    // Both ports stream reads: grants alternate in blocks of MAX_BURST, returns tagged one cycle later
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
    for (int i = 0; i < 12; i++) begin
      int p, pp;
      p  = (i / MAX_BURST) % 2;
      pp = ((i - 1) / MAX_BURST) % 2;
      @(negedge clk);
      chk($sformatf("burst%0d_gnt0", i), 32'(bus.gnt0), 32'(p == 0));
      chk($sformatf("burst%0d_gnt1", i), 32'(bus.gnt1), 32'(p == 1));
      if (i == 0) begin
        chk("burst0_rvalid", 32'(bus.rvalid0 | bus.rvalid1), 32'h0);
      end else begin
        chk($sformatf("burst%0d_rvalid0", i), 32'(bus.rvalid0), 32'(pp == 0));
        chk($sformatf("burst%0d_rvalid1", i), 32'(bus.rvalid1), 32'(pp == 1));
        chk($sformatf("burst%0d_rdata", i), bus.rdata, (pp == 1) ? 32'hDEADBEEF : 32'h0);
      end
      next_cycle();
    end

    // Simultaneous first arrival after reset, then DMA alone for ten cycles
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 16'h0080, 32'h0, 1'b1, 1'b0, 16'h0081, 32'h0);
    @(negedge clk);
    chk("first_tie_gnt0", 32'(bus.gnt0), 32'h1);
    chk("first_tie_gnt1", 32'(bus.gnt1), 32'h0);
    next_cycle();
    bus.req0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("solo%0d_gnt1", i), 32'(bus.gnt1), 32'h1);
      chk($sformatf("solo%0d_gnt0", i), 32'(bus.gnt0), 32'h0);
      next_cycle();
    end

    // Reset right after an accepted read swallows the return and clears the LED
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h000F, 32'h0000003C);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    chk("rstrd_gnt0", 32'(bus.gnt0), 32'h1);
    chk("rstrd_ledr_pre", 32'(ledr), 32'h03C);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstrd%0d_rvalid0", i), 32'(bus.rvalid0), 32'h0);
      chk($sformatf("rstrd%0d_rvalid1", i), 32'(bus.rvalid1), 32'h0);
      if (i > 0) chk($sformatf("rstrd%0d_ledr", i), 32'(ledr), 32'h0);
      next_cycle();
      if (i == 1) reset = 1'b0;
    end

    // Randomized traffic against the reference model
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m_owner = 0; m_last = 1; m_streak = 0; m_led = '0; m_pv = 1'b0; m_pp = 0; m_pd = '0;
    for (int p = 0; p < 2; p++) act[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 3) != 0) begin
          act[p] = 1'b1;
          wr[p]  = 1'($urandom_range(0, 1));
          ad[p]  = ($urandom_range(0, 5) == 0) ? LED_A : 16'h0080 + 16'($urandom_range(0, 7));
          dt[p]  = $urandom;
        end
      end
      drive(act[0], wr[0], ad[0], dt[0], act[1], wr[1], ad[1], dt[1]);

      if (act[0] && !act[1]) m_win = 0;
      else if (act[1] && !act[0]) m_win = 1;
      else if (act[0] && act[1]) begin
        if (m_streak == 0) m_win = 1 - m_last;
        else if (m_streak < MAX_BURST) m_win = m_owner;
        else m_win = 1 - m_owner;
      end else m_win = -1;

      @(negedge clk);
      chk("rnd_gnt0", 32'(bus.gnt0), 32'(m_win == 0));
      chk("rnd_gnt1", 32'(bus.gnt1), 32'(m_win == 1));
      chk("rnd_mem_we", 32'(mem_we), 32'(m_win >= 0 && wr[m_win >= 0 ? m_win : 0] && ad[m_win >= 0 ? m_win : 0] != LED_A));
      chk("rnd_rvalid0", 32'(bus.rvalid0), 32'(m_pv && m_pp == 0));
      chk("rnd_rvalid1", 32'(bus.rvalid1), 32'(m_pv && m_pp == 1));
      if (m_pv) chk("rnd_rdata", bus.rdata, m_pd);
      chk("rnd_ledr", 32'(ledr), 32'(m_led));

      m_pv = 1'b0;
      if (m_win >= 0) begin
        if (wr[m_win]) begin
          if (ad[m_win] == LED_A) m_led = dt[m_win][9:0];
          else m_mem[int'(ad[m_win])] = dt[m_win];
        end else begin
          m_pv = 1'b1;
          m_pp = m_win;
          if (ad[m_win] == LED_A) m_pd = {22'b0, m_led};
          else begin
            val  = m_mem.exists(int'(ad[m_win])) ? m_mem[int'(ad[m_win])] : 32'h0;
            m_pd = val;
          end
        end
        m_streak = (m_win == m_owner) ? m_streak + 1 : 1;
        m_owner  = m_win;
        m_last   = m_win;
        act[m_win] = 1'b0;
      end else begin
        m_streak = 0;
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single synchronous memory port between two requesters: port 0 is the processor core, port 1 is a program loader / DMA engine.
- Sits between the requesters and the memory block, and owns the memory-mapped LED register at LED_ADDR.
- Arbitration is round-robin with a bounded burst hold.
- Read data returns one cycle after acceptance, matching memory read latency.

Parameters:
- AW, 16, memory address width.
- DW, 32, data width.
- LED_ADDR, 16'h000F, address of the memory-mapped LED register.
- LED_W, 10, LED register width.
- MAX_BURST, 4, maximum consecutive accepted beats per grant while the other port is requesting (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  port request; held until accepted.
- we0 / we1  in  1  1 = write, 0 = read; valid with reqN.
- addr0 / addr1  in  AW  byte-less word address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  combinational; a beat is accepted in a cycle with reqN && gntN.
- rvalid0 / rvalid1  out  1  read data valid, one cycle after an accepted read.
- rdata  out  DW  shared read data, qualified by rvalidN.
- mem_addr  out  AW  to memory.
- mem_wdata  out  DW  to memory.
- mem_we  out  1  to memory.
- mem_rdata  in  DW  from memory, valid the cycle after the address is presented.
- ledr  out  LED_W  LED register contents.

Behaviour:
- Reset: the following take effect at the next clock edge and hold while reset is high.
  - owner ← 0; last ← 1 (so port 0 wins the first tie); burst_cnt ← 0.
  - rvalid0 = rvalid1 = 0; ledr ← 0; rd_pend ← 0.
  - gnt0 = gnt1 = 0; mem_we = 0.
- Reset mid-transaction discards any pending read return (no rvalid after reset).
- Grant logic (combinational, from req0, req1, owner, burst_cnt, last):
  - Only req0 → gnt0. Only req1 → gnt1.
  - Both requesting and no active burst → grant the port ≠ last.
  - Both requesting, active burst held by owner, burst_cnt < MAX_BURST → grant owner.
  - Both requesting, burst_cnt == MAX_BURST → grant the other port; burst_cnt ← 1 at accept.
  - Neither requesting → no grant; mem_we = 0; mem_addr holds its previous value (don't-care).
- At most one gnt is high in any cycle.
- On accept (reqN && gntN):
  - last ← N.
  - burst_cnt ← owner==N ? sat(burst_cnt+1) : 1; owner ← N.
  - Saturates at MAX_BURST.
  - Idle cycle (no req) → burst_cnt ← 0.
- Memory drive: mem_addr/mem_wdata muxed from the granted port; mem_we = we_granted && accept && (addr ≠ LED_ADDR).
- LED register:
  - Accepted write to LED_ADDR → ledr ← wdata[LED_W-1:0] at that edge; memory is not written.
  - Accepted read of LED_ADDR → next cycle rdata = {zero-extend, ledr}, taken from the value before any same-cycle write.
- Read return:
  - An accepted read sets rd_pend with port id and led flag.
  - Next cycle: rvalidN = 1 for exactly one cycle; rdata = mem_rdata, or the LED value if the led flag is set.
  - Back-to-back reads give rvalid every cycle.
  - Writes produce no rvalid.
- Read-after-write to the same address in consecutive beats returns the new data (memory write-first is not required, since the write completes at its own edge).
- A requester must hold req/we/addr/wdata stable until accepted; behaviour is undefined otherwise.
- Arithmetic: burst_cnt is width $clog2(MAX_BURST+1) and saturating; no wrap.

Decomposition:
- Shared package: LED_ADDR default, port-id constants PORT_CORE=0 / PORT_DMA=1, and the read-pending record type {valid, port, is_led}.
- One sub-module, rr_grant2: 2-way round-robin-with-burst grant logic (req, owner, burst_cnt, last → gnt). The datapath mux, LED register and read-return pipe stay in the top of this block.

Test Plan:
- Reset held 2 cycles with req0=1 → gnt0=0, rvalid=0, ledr=0; release → gnt0=1 in the first cycle.
- Port 0 writes 32'h0000_0155 to addr 16'h000F → ledr=10'h155, mem_we=0. Then it reads 16'h000F → rvalid0 next cycle, rdata=32'h155.
- Port 1 writes 32'hDEAD_BEEF to 16'h0040, then reads 16'h0040 back-to-back → mem_we=1 for one cycle, rvalid1 the cycle after the read, rdata=32'hDEAD_BEEF.
- req0 and req1 held continuously for reads, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0…; each rvalid tagged to the correct port one cycle later.
- Alternating single requests with simultaneous first arrival after reset → port 0 granted first, then port 1. With only req1 asserted for 10 cycles → gnt1 every cycle, no starvation stall.
- Assert reset the cycle after an accepted read → no rvalid is produced; ledr returns to 0.
